batch_eval_ctrl: RTL and testbench

BATCH_EVAL_CTRL -- requirements
Module: batch_eval_ctrl

---
 rtl/mnist_pkg.sv | 25 ++
 rtl/seq_div.sv | 76 +++++++
 rtl/batch_eval_ctrl.sv | 270 +++++++++++++++++++++++++++
 tb/tb_batch_eval_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mnist_pkg.sv
// Shared types and width helpers for the batch evaluation controller.
// Widths derived with width_of() are never narrower than one bit.
package mnist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_STREAM = 3'd1,
        ST_WAIT   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DIV    = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam int unsigned ACC_W     = 32'd7;
    localparam int unsigned PCT_SCALE = 32'd100;

    function automatic int unsigned width_of(input int unsigned n);
        if (n <= 32'd1) begin
            return 32'd1;
        end else begin
            return int'($clog2(n));
        end
    endfunction

endpackage

// File: rtl/seq_div.sv
// Restoring unsigned divider, one quotient bit per cycle.
// A start pulse loads the operands; done pulses once the quotient is final.
module seq_div #(
    parameter int unsigned N_W = 16,
    parameter int unsigned D_W = 8,
    parameter int unsigned Q_W = 7
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           srst,
    input  logic           start,
    input  logic [N_W-1:0] dividend,
    input  logic [D_W-1:0] divisor,
    output logic           done,
    output logic [Q_W-1:0] quotient
);

    localparam int unsigned C_W = $clog2(N_W + 1);

    logic [N_W-1:0] dq_r;
    logic [D_W-1:0] rem_r;
    logic [C_W-1:0] cnt_r;
    logic           run_r;
    logic           done_r;
    logic [D_W:0]   rem_sh_s;
    logic [D_W-1:0] rem_nx_s;
    logic           ge_s;

    // Trial subtraction of the divisor from the shifted partial remainder.
    always_comb begin
        rem_sh_s = {rem_r, dq_r[N_W-1]};
        ge_s     = (rem_sh_s >= {1'b0, divisor});
        if (ge_s) begin
            rem_nx_s = D_W'(rem_sh_s - {1'b0, divisor});
        end else begin
            rem_nx_s = rem_sh_s[D_W-1:0];
        end
    end

    // Dividend bits shift out the top while quotient bits shift in below.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dq_r   <= {N_W{1'b0}};
            rem_r  <= {D_W{1'b0}};
            cnt_r  <= {C_W{1'b0}};
            run_r  <= 1'b0;
            done_r <= 1'b0;
        end else if (srst) begin
            dq_r   <= {N_W{1'b0}};
            rem_r  <= {D_W{1'b0}};
            cnt_r  <= {C_W{1'b0}};
            run_r  <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (run_r) begin
                dq_r  <= {dq_r[N_W-2:0], ge_s};
                rem_r <= rem_nx_s;
                cnt_r <= cnt_r - C_W'(1);
                if (cnt_r == C_W'(1)) begin
                    run_r  <= 1'b0;
                    done_r <= 1'b1;
                end
            end else if (start) begin
                dq_r  <= dividend;
                rem_r <= {D_W{1'b0}};
                cnt_r <= C_W'(N_W);
                run_r <= 1'b1;
            end
        end
    end

    assign done     = done_r;
    assign quotient = dq_r[Q_W-1:0];

endmodule

// File: rtl/batch_eval_ctrl.sv
// Streams a batch of images from pixel memory into a classifier, scores each
// prediction against its label and reports hit/timeout/low-confidence counts.
module batch_eval_ctrl
    import mnist_pkg::*;
#(
    parameter int unsigned PIX_PER_IMG = 784,
    parameter int unsigned PIX_W       = 1,
    parameter int unsigned MAX_IMG     = 1000,
    parameter int unsigned LABEL_W     = 4,
    parameter int unsigned CONF_W      = 8,
    parameter int unsigned CONF_THR    = 128,
    parameter int unsigned TIMEOUT     = 4096
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         start,
    input  logic                                         abort,
    input  logic [width_of(MAX_IMG + 1)-1:0]             img_count,
    output logic                                         pix_rd_en,
    output logic [width_of(MAX_IMG * PIX_PER_IMG)-1:0]   pix_addr,
    input  logic [PIX_W-1:0]                             pix_rdata,
    output logic [width_of(MAX_IMG)-1:0]                 label_addr,
    input  logic [LABEL_W-1:0]                           label_rdata,
    output logic [PIX_W-1:0]                             data_out,
    output logic                                         data_valid,
    output logic                                         frame_start,
    input  logic [LABEL_W-1:0]                           prediction,
    input  logic [CONF_W-1:0]                            confidence,
    input  logic                                         pred_valid,
    output logic                                         busy,
    output logic                                         done,
    output logic                                         res_valid,
    output logic [width_of(MAX_IMG)-1:0]                 res_idx,
    output logic [LABEL_W-1:0]                           res_pred,
    output logic                                         res_hit,
    output logic [width_of(MAX_IMG + 1)-1:0]             hit_cnt,
    output logic [width_of(MAX_IMG + 1)-1:0]             timeout_cnt,
    output logic [width_of(MAX_IMG + 1)-1:0]             lowconf_cnt,
    output logic [ACC_W-1:0]                             acc_pct
);

    localparam int unsigned CNT_W     = width_of(MAX_IMG + 1);
    localparam int unsigned IDX_W     = width_of(MAX_IMG);
    localparam int unsigned ADDR_W    = width_of(MAX_IMG * PIX_PER_IMG);
    localparam int unsigned BASE_W    = ADDR_W + 1;
    localparam int unsigned PIX_IDX_W = width_of(PIX_PER_IMG);
    localparam int unsigned TO_W      = width_of(TIMEOUT);
    localparam int unsigned DIVD_W    = CNT_W + ACC_W;
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_IMG);
    localparam logic [BASE_W-1:0] PIX_STEP = BASE_W'(PIX_PER_IMG);

    state_t state_r, state_nx;

    logic [CNT_W-1:0]     img_total_r;
    logic [IDX_W-1:0]     img_idx_r;
    logic [PIX_IDX_W-1:0] pix_idx_r;
    logic [BASE_W-1:0]    base_r;
    logic [TO_W-1:0]      wait_cnt_r;
    logic [LABEL_W-1:0]   pred_r;
    logic [CONF_W-1:0]    conf_r;
    logic                 to_r;
    logic                 div_started_r;
    logic                 pix_rd_en_r, data_valid_r, frame_start_r;
    logic [ADDR_W-1:0]    pix_addr_r;
    logic [IDX_W-1:0]     label_addr_r, res_idx_r;
    logic                 busy_r, done_r, res_valid_r, res_hit_r;
    logic [LABEL_W-1:0]   res_pred_r;
    logic [CNT_W-1:0]     hit_cnt_r, timeout_cnt_r, lowconf_cnt_r;
    logic [ACC_W-1:0]     acc_pct_r;

    logic                 pix_last_s, wait_exp_s, img_last_s, hit_s;
    logic                 div_start_s, div_done_s;
    logic [ACC_W-1:0]     div_quo_s;
    logic [DIVD_W-1:0]    dividend_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v >= CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    // Next-state decode; abort wins over every other condition.
    always_comb begin
        state_nx    = state_r;
        div_start_s = 1'b0;
        pix_last_s  = (pix_idx_r == PIX_IDX_W'(PIX_PER_IMG - 1));
        wait_exp_s  = (wait_cnt_r == TO_W'(TIMEOUT - 1));
        img_last_s  = ((CNT_W'(img_idx_r) + CNT_W'(1)) >= img_total_r);
        hit_s       = (pred_r == label_rdata) && !to_r;
        if (abort && (state_r != ST_IDLE)) begin
            state_nx = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_nx = (img_count == {CNT_W{1'b0}}) ? ST_DONE : ST_STREAM;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
                ST_STREAM: state_nx = pix_last_s ? ST_WAIT : ST_STREAM;
                ST_WAIT:   state_nx = (pred_valid || wait_exp_s) ? ST_CHECK : ST_WAIT;
                ST_CHECK:  state_nx = img_last_s ? ST_DIV : ST_STREAM;
                ST_DIV: begin
                    div_start_s = !div_started_r;
                    state_nx    = div_done_s ? ST_DONE : ST_DIV;
                end
                ST_DONE:   state_nx = ST_IDLE;
                default:   state_nx = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Datapath, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            img_total_r   <= {CNT_W{1'b0}};
            img_idx_r     <= {IDX_W{1'b0}};
            pix_idx_r     <= {PIX_IDX_W{1'b0}};
            base_r        <= {BASE_W{1'b0}};
            wait_cnt_r    <= {TO_W{1'b0}};
            pred_r        <= {LABEL_W{1'b0}};
            conf_r        <= {CONF_W{1'b0}};
            to_r          <= 1'b0;
            div_started_r <= 1'b0;
            pix_rd_en_r   <= 1'b0;
            data_valid_r  <= 1'b0;
            frame_start_r <= 1'b0;
            pix_addr_r    <= {ADDR_W{1'b0}};
            label_addr_r  <= {IDX_W{1'b0}};
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            res_valid_r   <= 1'b0;
            res_idx_r     <= {IDX_W{1'b0}};
            res_pred_r    <= {LABEL_W{1'b0}};
            res_hit_r     <= 1'b0;
            hit_cnt_r     <= {CNT_W{1'b0}};
            timeout_cnt_r <= {CNT_W{1'b0}};
            lowconf_cnt_r <= {CNT_W{1'b0}};
            acc_pct_r     <= {ACC_W{1'b0}};
        end else begin
            pix_rd_en_r   <= (state_nx == ST_STREAM);
            data_valid_r  <= (state_r == ST_STREAM) && !abort;
            frame_start_r <= (state_r == ST_STREAM) && (pix_idx_r == {PIX_IDX_W{1'b0}}) && !abort;
            busy_r        <= (state_nx == ST_STREAM) || (state_nx == ST_WAIT) ||
                             (state_nx == ST_CHECK) || (state_nx == ST_DIV);
            done_r        <= (state_nx == ST_DONE);
            res_valid_r   <= 1'b0;
            if ((state_r == ST_IDLE) || !abort) begin
                case (state_r)
                    ST_IDLE: begin
                        if (start) begin
                            img_total_r   <= img_count;
                            img_idx_r     <= {IDX_W{1'b0}};
                            pix_idx_r     <= {PIX_IDX_W{1'b0}};
                            base_r        <= {BASE_W{1'b0}};
                            pix_addr_r    <= {ADDR_W{1'b0}};
                            hit_cnt_r     <= {CNT_W{1'b0}};
                            timeout_cnt_r <= {CNT_W{1'b0}};
                            lowconf_cnt_r <= {CNT_W{1'b0}};
                            acc_pct_r     <= {ACC_W{1'b0}};
                        end
                    end
                    ST_STREAM: begin
                        // Address of the next read: current base plus next pixel index.
                        if (pix_last_s) begin
                            pix_idx_r    <= {PIX_IDX_W{1'b0}};
                            base_r       <= base_r + PIX_STEP;
                            pix_addr_r   <= ADDR_W'(base_r + PIX_STEP);
                            wait_cnt_r   <= {TO_W{1'b0}};
                            label_addr_r <= img_idx_r;
                        end else begin
                            pix_idx_r  <= pix_idx_r + PIX_IDX_W'(1);
                            pix_addr_r <= ADDR_W'(base_r + BASE_W'(pix_idx_r) + BASE_W'(1));
                        end
                    end
                    ST_WAIT: begin
                        wait_cnt_r <= wait_cnt_r + TO_W'(1);
                        if (pred_valid) begin
                            pred_r <= prediction;
                            conf_r <= confidence;
                            to_r   <= 1'b0;
                        end else if (wait_exp_s) begin
                            pred_r        <= {LABEL_W{1'b0}};
                            conf_r        <= {CONF_W{1'b0}};
                            to_r          <= 1'b1;
                            timeout_cnt_r <= sat_inc(timeout_cnt_r);
                        end
                    end
                    ST_CHECK: begin
                        res_valid_r <= 1'b1;
                        res_idx_r   <= img_idx_r;
                        res_pred_r  <= pred_r;
                        res_hit_r   <= hit_s;
                        if (hit_s) begin
                            hit_cnt_r <= sat_inc(hit_cnt_r);
                        end
                        if (!to_r && (conf_r < CONF_W'(CONF_THR))) begin
                            lowconf_cnt_r <= sat_inc(lowconf_cnt_r);
                        end
                        if (!img_last_s) begin
                            img_idx_r <= img_idx_r + IDX_W'(1);
                        end
                    end
                    ST_DIV: begin
                        div_started_r <= 1'b1;
                        if (div_done_s) begin
                            acc_pct_r     <= div_quo_s;
                            div_started_r <= 1'b0;
                        end
                    end
                    ST_DONE: begin
                        div_started_r <= 1'b0;
                    end
                    default: begin
                        div_started_r <= 1'b0;
                    end
                endcase
            end else begin
                div_started_r <= 1'b0;
            end
        end
    end

    assign dividend_s = DIVD_W'(hit_cnt_r) * DIVD_W'(PCT_SCALE);

    seq_div #(
        .N_W(DIVD_W),
        .D_W(CNT_W),
        .Q_W(ACC_W)
    ) u_seq_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .srst    (abort),
        .start   (div_start_s),
        .dividend(dividend_s),
        .divisor (img_total_r),
        .done    (div_done_s),
        .quotient(div_quo_s)
    );

    assign pix_rd_en   = pix_rd_en_r;
    assign pix_addr    = pix_addr_r;
    assign label_addr  = label_addr_r;
    assign data_out    = data_valid_r ? pix_rdata : {PIX_W{1'b0}};
    assign data_valid  = data_valid_r;
    assign frame_start = frame_start_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign res_valid   = res_valid_r;
    assign res_idx     = res_idx_r;
    assign res_pred    = res_pred_r;
    assign res_hit     = res_hit_r;
    assign hit_cnt     = hit_cnt_r;
    assign timeout_cnt = timeout_cnt_r;
    assign lowconf_cnt = lowconf_cnt_r;
    assign acc_pct     = acc_pct_r;

endmodule

// File: tb/tb_batch_eval_ctrl.sv
// Directed bench for batch_eval_ctrl with 4-pixel images, 8-image batches
// and a 16-cycle classifier timeout.
module tb_batch_eval_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] img_count = 4'd0;
    logic       pix_rd_en;
    logic [4:0] pix_addr;
    logic       pix_rdata = 1'b0;
    logic [2:0] label_addr;
    logic [3:0] label_rdata = 4'd0;
    logic       data_out, data_valid, frame_start;
    logic [3:0] prediction = 4'd0;
    logic [7:0] confidence = 8'd0;
    logic       pred_valid = 1'b0;
    logic       busy, done, res_valid;
    logic [2:0] res_idx;
    logic [3:0] res_pred;
    logic       res_hit;
    logic [3:0] hit_cnt, timeout_cnt, lowconf_cnt;
    logic [6:0] acc_pct;

    int n_assert = 0;
    int n_fail = 0;

    logic [3:0] labels [8];
    logic       no_resp [8];
    logic       wrong [8];
    logic [3:0] wrong_val = 4'd7;
    logic [7:0] conf_val = 8'd200;

    int done_cnt = 0, fs_cnt = 0, dv_cnt = 0, dout_err = 0, res_n = 0;
    logic [2:0] res_idx_a [64];
    logic [3:0] res_pred_a [64];
    logic       res_hit_a [64];

    batch_eval_ctrl #(
        .PIX_PER_IMG(4), .PIX_W(1), .MAX_IMG(8), .LABEL_W(4),
        .CONF_W(8), .CONF_THR(128), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .img_count(img_count), .pix_rd_en(pix_rd_en), .pix_addr(pix_addr),
        .pix_rdata(pix_rdata), .label_addr(label_addr), .label_rdata(label_rdata),
        .data_out(data_out), .data_valid(data_valid), .frame_start(frame_start),
        .prediction(prediction), .confidence(confidence), .pred_valid(pred_valid),
        .busy(busy), .done(done), .res_valid(res_valid), .res_idx(res_idx),
        .res_pred(res_pred), .res_hit(res_hit), .hit_cnt(hit_cnt),
        .timeout_cnt(timeout_cnt), .lowconf_cnt(lowconf_cnt), .acc_pct(acc_pct)
    );

    always #5 clk = ~clk;

    function automatic logic pix_fn(input logic [4:0] a);
        return a[0] ^ a[2];
    endfunction

    // One-cycle-latency pixel and label memories.
    always @(posedge clk) begin
        pix_rdata   <= pix_rd_en ? pix_fn(pix_addr) : 1'b0;
        label_rdata <= labels[label_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Classifier: answers two cycles after the fourth pixel of a frame.
    initial begin : classifier
        int pcount;
        int img;
        pcount = 0;
        forever begin
            @(negedge clk);
            if (frame_start) pcount = 0;
            if (data_valid) pcount++;
            if (data_valid && pcount == 4) begin
                repeat (2) @(negedge clk);
                img = int'(label_addr);
                if (!no_resp[img]) begin
                    pred_valid = 1'b1;
                    prediction = wrong[img] ? wrong_val : labels[img];
                    confidence = conf_val;
                    @(negedge clk);
                    pred_valid = 1'b0;
                end
            end
        end
    end

    // Output monitor.
    initial begin : monitor
        logic       prev_rd;
        logic [4:0] prev_addr;
        prev_rd = 1'b0;
        prev_addr = 5'd0;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (frame_start) fs_cnt++;
            if (data_valid) begin
                dv_cnt++;
                if (!prev_rd || (data_out !== pix_fn(prev_addr))) dout_err++;
            end
            if (res_valid && res_n < 64) begin
                res_idx_a[res_n]  = res_idx;
                res_pred_a[res_n] = res_pred;
                res_hit_a[res_n]  = res_hit;
                res_n++;
            end
            prev_rd = pix_rd_en;
            prev_addr = pix_addr;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic pulse_start(input logic [3:0] n);
        @(negedge clk);
        img_count = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_rd(input logic level, input string tag);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (pix_rd_en == level) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq({tag, "_rd_wait"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_addr(input logic [4:0] a, input string tag);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (pix_rd_en && pix_addr == a) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq({tag, "_addr_wait"}, 32'(seen), 32'd1);
    endtask

    initial begin : main
        int db, fb, vb, rb, gap;
        logic seen;
        labels = '{4'd3, 4'd2, 4'd9, 4'd1, 4'd4, 4'd6, 4'd0, 4'd8};
        for (int i = 0; i < 8; i++) begin
            no_resp[i] = 1'b0;
            wrong[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_rd_en", 32'(pix_rd_en), 32'd0);
        check_eq("rst_addr", 32'(pix_addr), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_acc", 32'(acc_pct), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // all three images echo their label with high confidence; stray start ignored
        db = done_cnt; fb = fs_cnt; vb = dv_cnt; rb = res_n;
        pulse_start(4'd3);
        repeat (3) @(negedge clk);
        img_count = 4'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t1");
        repeat (3) @(negedge clk);
        check_eq("t1_hit", 32'(hit_cnt), 32'd3);
        check_eq("t1_lowconf", 32'(lowconf_cnt), 32'd0);
        check_eq("t1_timeout", 32'(timeout_cnt), 32'd0);
        check_eq("t1_acc", 32'(acc_pct), 32'd100);
        check_eq("t1_done_cnt", 32'(done_cnt - db), 32'd1);
        check_eq("t1_frames", 32'(fs_cnt - fb), 32'd3);
        check_eq("t1_beats", 32'(dv_cnt - vb), 32'd12);
        check_eq("t1_dout_err", 32'(dout_err), 32'd0);
        check_eq("t1_busy", 32'(busy), 32'd0);
        check_eq("t1_res_n", 32'(res_n - rb), 32'd3);
        check_eq("t1_res2_idx", 32'(res_idx_a[rb+2]), 32'd2);
        check_eq("t1_res2_hit", 32'(res_hit_a[rb+2]), 32'd1);

        // image 1 mispredicted
        wrong[1] = 1'b1;
        rb = res_n;
        pulse_start(4'd3);
        wait_done("t2");
        check_eq("t2_res1_idx", 32'(res_idx_a[rb+1]), 32'd1);
        check_eq("t2_res1_hit", 32'(res_hit_a[rb+1]), 32'd0);
        check_eq("t2_res1_pred", 32'(res_pred_a[rb+1]), 32'd7);
        check_eq("t2_hit", 32'(hit_cnt), 32'd2);
        check_eq("t2_acc", 32'(acc_pct), 32'd66);
        wrong[1] = 1'b0;

        // image 0 never answered: 16 WAIT cycles, CHECK, then res_valid
        no_resp[0] = 1'b1;
        pulse_start(4'd2);
        wait_rd(1'b1, "t3a");
        wait_rd(1'b0, "t3b");
        gap = 0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            gap++;
            if (res_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("t3_res_seen", 32'(seen), 32'd1);
        check_eq("t3_rdlow_to_res", 32'(gap), 32'd17);
        check_eq("t3_res_pred", 32'(res_pred), 32'd0);
        check_eq("t3_res_hit", 32'(res_hit), 32'd0);
        wait_rd(1'b1, "t3c");
        check_eq("t3_next_addr", 32'(pix_addr), 32'd4);
        wait_done("t3");
        check_eq("t3_timeout", 32'(timeout_cnt), 32'd1);
        check_eq("t3_hit", 32'(hit_cnt), 32'd1);
        check_eq("t3_lowconf", 32'(lowconf_cnt), 32'd0);
        check_eq("t3_acc", 32'(acc_pct), 32'd50);
        no_resp[0] = 1'b0;

        // empty batch
        pulse_start(4'd0);
        seen = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (done) seen = 1'b1;
            @(negedge clk);
        end
        check_eq("t4_done_fast", 32'(seen), 32'd1);
        check_eq("t4_acc", 32'(acc_pct), 32'd0);
        check_eq("t4_hit", 32'(hit_cnt), 32'd0);
        check_eq("t4_timeout", 32'(timeout_cnt), 32'd0);

        // low confidence on both images
        conf_val = 8'd50;
        pulse_start(4'd2);
        wait_done("t4b");
        check_eq("t4b_lowconf", 32'(lowconf_cnt), 32'd2);
        check_eq("t4b_hit", 32'(hit_cnt), 32'd2);
        check_eq("t4b_acc", 32'(acc_pct), 32'd100);
        conf_val = 8'd200;

        // abort on pixel 2 of image 1
        db = done_cnt;
        pulse_start(4'd3);
        wait_addr(5'd6, "t5");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("t5_rd_en", 32'(pix_rd_en), 32'd0);
        check_eq("t5_dvalid", 32'(data_valid), 32'd0);
        check_eq("t5_busy", 32'(busy), 32'd0);
        repeat (40) @(negedge clk);
        check_eq("t5_no_done", 32'(done_cnt - db), 32'd0);
        check_eq("t5_hit_held", 32'(hit_cnt), 32'd1);
        check_eq("t5_busy_late", 32'(busy), 32'd0);

        // reset in the middle of image 1, then a fresh one-image batch
        pulse_start(4'd3);
        wait_addr(5'd5, "t6");
        rst_n = 1'b0;
        #1;
        check_eq("t6_rd_en", 32'(pix_rd_en), 32'd0);
        check_eq("t6_addr", 32'(pix_addr), 32'd0);
        check_eq("t6_busy", 32'(busy), 32'd0);
        check_eq("t6_hit", 32'(hit_cnt), 32'd0);
        check_eq("t6_dvalid", 32'(data_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        db = done_cnt;
        pulse_start(4'd1);
        check_eq("t6_restart_rd", 32'(pix_rd_en), 32'd1);
        check_eq("t6_restart_addr", 32'(pix_addr), 32'd0);
        wait_done("t6");
        repeat (2) @(negedge clk);
        check_eq("t6_done_cnt", 32'(done_cnt - db), 32'd1);
        check_eq("t6_hit_after", 32'(hit_cnt), 32'd1);
        check_eq("t6_acc_after", 32'(acc_pct), 32'd100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
